mult_seq16: RTL and testbench
=============================

# mult_seq16

Iterative unsigned shift-and-add multiplier for the CPU execute stage. It sits directly upstream of the 16-bit carry-look-ahead adder datapath. Each cycle it drives one partial-product addition: the multiplicand is added into the upper half of a running product, then the product is shifted right. A start/busy/done handshake lets the control unit stall the pipeline for the fixed multiply latency. The block outputs the full 32-bit product and a flag indicating that the product does not fit in 16 bits.

## Interface
- WIDTH, 16, operand width; product is 2*WIDTH bits, iteration count is WIDTH.

- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- A  input  WIDTH  multiplicand (unsigned); sampled with accepted start.
- B  input  WIDTH  multiplier (unsigned); sampled with accepted start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse, high while in DONE.
- Product  output  2*WIDTH  result register; valid when done=1, held afterwards.
- Ovfl  output  1  Product[2*WIDTH-1:WIDTH] != 0; valid with Product.

## Operation
- States: IDLE, RUN, DONE.
  - IDLE -> RUN on an edge with start=1.
  - RUN -> DONE on the edge that completes step WIDTH.
  - DONE -> IDLE unconditionally on the next edge.
- Accept (IDLE, start=1), registers load as follows:
  - mcand <= A
  - {hi,lo} <= {0, B}
  - carry <= 0
  - count <= 0
- Step (each RUN edge):
  - sum[WIDTH:0] = {1'b0,hi} + (lo[0] ? mcand : 0).
  - {hi,lo} <= {sum, lo} >> 1, a (2*WIDTH+1)-bit right shift. sum[WIDTH] enters hi[WIDTH-1], and the bit shifted out of lo[0] is discarded.
  - count <= count+1.
  - Leave RUN when count reaches WIDTH-1 before increment.
- Arithmetic:
  - Unsigned only; no sign extension.
  - The carry out of the WIDTH-bit add is never lost.
  - Product = {hi,lo} = A*B exactly, mod 2^(2*WIDTH), which never wraps.
- Product and Ovfl are combinational from {hi,lo}. They are stable and meaningful only in DONE and in the following IDLE. The values hold until the next accepted start.
- start in RUN or DONE is ignored; it is not queued.
- A/B changes after acceptance have no effect.

## Timing
- Reset (rst=1 at an edge), from any state and including mid-RUN:
  - state=IDLE
  - mcand, hi, lo, count = 0
  - busy=0, done=0, Product=0, Ovfl=0
  - The in-flight multiply is abandoned with no done pulse.
  - rst has priority over start.
- Latency: start accepted at edge E0. busy=1 from E0 through edge E0+WIDTH. Edges E1..E16 perform the WIDTH steps (WIDTH=16).
- done=1 and the result are valid in the cycle after edge E0+WIDTH; done falls at E0+WIDTH+1.
- Start-to-done: WIDTH+1 cycles. Minimum start-to-start spacing: WIDTH+2 cycles, because the next start is accepted in IDLE at E0+WIDTH+2 or later.
- busy and done are never high together. Each is a registered state decode, with no combinational path from start.

## Test plan
- Reset, then A=3, B=5, start for one cycle -> busy high for 16 cycles; done pulses once, 17 cycles after accept; Product=0x0000000F, Ovfl=0.
- A=0xFFFF, B=0xFFFF -> Product=0xFFFE0001, Ovfl=1; checks the carry into hi on every step.
- A=0x1234, B=0 and A=0, B=0xBEEF -> Product=0, Ovfl=0; A=0x0100, B=0x0100 -> Product=0x00010000, Ovfl=1.
- Hold start=1 continuously with A/B changing every cycle:
  - First accept multiplies the accept-cycle operands.
  - No re-accept occurs during RUN/DONE.
  - Next accept happens in the IDLE cycle after done.
  - Product holds through IDLE until that accept.
- Assert rst on the 8th RUN cycle -> next cycle busy=0, done=0, Product=0; no done pulse. A new multiply of 7*9 then yields 0x0000003F.
- Random unsigned A/B, 1000 back-to-back operations -> Product == A*B and Ovfl == (A*B > 0xFFFF) for each.

Source files
------------

// File: rtl/mult_seq16_if.sv
// Handshake and operand/result bundle between the execute-stage control and mult_seq16.
// The master drives start and operands; the slave returns status and the product.
interface mult_seq16_if #(
    parameter int WIDTH = 16
);
    logic                 start;
    logic [WIDTH-1:0]     A;
    logic [WIDTH-1:0]     B;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   Product;
    logic                 Ovfl;

    modport master (
        output start, A, B,
        input  busy, done, Product, Ovfl
    );

    modport slave (
        input  start, A, B,
        output busy, done, Product, Ovfl
    );
endinterface

// File: rtl/mult_seq16.sv
// Iterative unsigned shift-and-add multiplier: one partial-product add per RUN cycle,
// WIDTH steps per multiply, start/busy/done handshake towards the pipeline control.
module mult_seq16 #(
    parameter int WIDTH = 16
) (
    input  logic          clk,
    input  logic          rst,
    mult_seq16_if.slave   bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_reg;
    state_t             state_next;
    logic [WIDTH-1:0]   mcand_reg;
    logic [WIDTH-1:0]   hi_reg;
    logic [WIDTH-1:0]   lo_reg;
    logic [CW-1:0]      count_reg;
    logic [WIDTH-1:0]   addend;
    logic [WIDTH:0]     sum;
    logic               last_step;
    logic               accept;

    // Multiplicand gated by the current multiplier bit.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_addend
            assign addend[gi] = mcand_reg[gi] & lo_reg[0];
        end
    endgenerate

    // Carry out lands in sum[WIDTH] and is shifted into hi, so it is never lost.
    assign sum       = {1'b0, hi_reg} + {1'b0, addend};
    assign last_step = (count_reg == CW'(WIDTH - 1));
    assign accept    = (state_reg == IDLE) && bus.start;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.start) state_next = RUN;
            RUN:     if (last_step) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_reg <= '0;
            hi_reg    <= '0;
            lo_reg    <= '0;
            count_reg <= '0;
        end else if (accept) begin
            mcand_reg <= bus.A;
            hi_reg    <= '0;
            lo_reg    <= bus.B;
            count_reg <= '0;
        end else if (state_reg == RUN) begin
            // {sum, lo} >> 1: lo[0] has been consumed and drops off the end.
            hi_reg    <= sum[WIDTH:1];
            lo_reg    <= {sum[0], lo_reg[WIDTH-1:1]};
            count_reg <= count_reg + 1'b1;
        end
    end

    assign bus.busy    = (state_reg == RUN);
    assign bus.done    = (state_reg == DONE);
    assign bus.Product = {hi_reg, lo_reg};
    assign bus.Ovfl    = |hi_reg;
endmodule

// File: tb/tb_mult_seq16.sv
// Self-checking bench for mult_seq16: vector table, held-start, mid-RUN reset and
// random back-to-back operations, with a scoreboard queue checked on every done pulse.
module tb_mult_seq16;
    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] prod;
        logic        ovfl;
    } vec_t;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    vec_t sb[$];
    vec_t exp_v;

    mult_seq16_if #(.WIDTH(16)) dif ();

    mult_seq16 #(.WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t model(input logic [15:0] a, input logic [15:0] b);
        vec_t v;
        v.a    = a;
        v.b    = b;
        v.prod = 32'(a) * 32'(b);
        v.ovfl = (v.prod > 32'h0000_FFFF);
        return v;
    endfunction

    // Scoreboard: every done pulse consumes the oldest expected result.
    always @(negedge clk) begin
        if (!rst && dif.done) begin
            chk("busy_done_exclusive", {31'b0, dif.busy}, 32'd0);
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=done expected=no_done");
            end else begin
                exp_v = sb.pop_front();
                chk("product", dif.Product, exp_v.prod);
                chk("ovfl", {31'b0, dif.Ovfl}, {31'b0, exp_v.ovfl});
                $display("txn a=0x%04h b=0x%04h product=0x%08h ovfl=%0d", exp_v.a, exp_v.b,
                         dif.Product, dif.Ovfl);
            end
        end
    end

    // Called at a negedge; returns at the IDLE negedge following done, ready for back-to-back.
    task automatic do_mult(input logic [15:0] a, input logic [15:0] b);
        int  cyc      = 1;
        int  busy_cnt = 0;
        bit  seen     = 0;
        logic [31:0] held;
        dif.A     = a;
        dif.B     = b;
        dif.start = 1'b1;
        sb.push_back(model(a, b));
        @(negedge clk);
        dif.start = 1'b0;
        dif.A     = 16'($urandom);
        dif.B     = 16'($urandom);
        while (!seen && cyc < 40) begin
            if (dif.done) begin
                seen = 1;
            end else begin
                if (dif.busy) busy_cnt++;
                @(negedge clk);
                cyc++;
            end
        end
        chk("done_seen", {31'b0, seen}, 32'd1);
        chk("done_latency", 32'(cyc), 32'd17);
        chk("busy_cycles", 32'(busy_cnt), 32'd16);
        held = dif.Product;
        @(negedge clk);
        chk("done_pulse_width", {31'b0, dif.done}, 32'd0);
        chk("product_hold", dif.Product, held);
    endtask

    vec_t tbl[8];

    initial begin
        vec_t v0;
        int   cyc;
        bit   seen;

        tbl[0] = '{16'h0003, 16'h0005, 32'h0000_000F, 1'b0};
        tbl[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 1'b1};
        tbl[2] = '{16'h1234, 16'h0000, 32'h0000_0000, 1'b0};
        tbl[3] = '{16'h0000, 16'hBEEF, 32'h0000_0000, 1'b0};
        tbl[4] = '{16'h0100, 16'h0100, 32'h0001_0000, 1'b1};
        tbl[5] = '{16'hFFFF, 16'h0001, 32'h0000_FFFF, 1'b0};
        tbl[6] = '{16'h8000, 16'h0002, 32'h0001_0000, 1'b1};
        tbl[7] = '{16'h0001, 16'h0001, 32'h0000_0001, 1'b0};

        rst       = 1'b1;
        dif.start = 1'b0;
        dif.A     = '0;
        dif.B     = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", {31'b0, dif.busy}, 32'd0);
        chk("reset_done", {31'b0, dif.done}, 32'd0);
        chk("reset_product", dif.Product, 32'd0);
        chk("reset_ovfl", {31'b0, dif.Ovfl}, 32'd0);
        rst = 1'b0;

        // Table vectors; the hand-written expectations are checked against the model too.
        for (int i = 0; i < 8; i++) begin
            v0 = model(tbl[i].a, tbl[i].b);
            chk("table_model", v0.prod, tbl[i].prod);
            do_mult(tbl[i].a, tbl[i].b);
        end

        // Held start with operands changing every cycle.
        dif.start = 1'b1;
        dif.A     = 16'h0123;
        dif.B     = 16'h0456;
        v0        = model(16'h0123, 16'h0456);
        sb.push_back(v0);
        cyc  = 0;
        seen = 0;
        while (!seen && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (dif.done) seen = 1;
            else begin
                dif.A = 16'($urandom);
                dif.B = 16'($urandom);
            end
        end
        chk("held_done_latency", 32'(cyc), 32'd17);
        @(negedge clk);
        chk("held_idle_busy", {31'b0, dif.busy}, 32'd0);
        chk("held_idle_done", {31'b0, dif.done}, 32'd0);
        chk("held_idle_product", dif.Product, v0.prod);
        dif.A = 16'hABCD;
        dif.B = 16'h0010;
        sb.push_back(model(16'hABCD, 16'h0010));
        @(negedge clk);
        chk("held_reaccept_busy", {31'b0, dif.busy}, 32'd1);
        dif.start = 1'b0;
        cyc  = 0;
        seen = 0;
        while (!seen && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (dif.done) seen = 1;
        end
        chk("held_second_latency", 32'(cyc), 32'd16);
        @(negedge clk);

        // Reset on the 8th RUN cycle, with start held to confirm reset priority.
        dif.A     = 16'h1234;
        dif.B     = 16'h5678;
        dif.start = 1'b1;
        @(negedge clk);
        dif.start = 1'b0;
        repeat (7) @(negedge clk);
        chk("pre_abort_busy", {31'b0, dif.busy}, 32'd1);
        rst       = 1'b1;
        dif.start = 1'b1;
        @(negedge clk);
        chk("abort_busy", {31'b0, dif.busy}, 32'd0);
        chk("abort_done", {31'b0, dif.done}, 32'd0);
        chk("abort_product", dif.Product, 32'd0);
        chk("abort_ovfl", {31'b0, dif.Ovfl}, 32'd0);
        rst       = 1'b0;
        dif.start = 1'b0;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (dif.done) seen = 1;
        end
        chk("abort_no_done", {31'b0, seen}, 32'd0);
        do_mult(16'd7, 16'd9);

        // Random back-to-back operations.
        for (int i = 0; i < 1000; i++) begin
            do_mult(16'($urandom), 16'($urandom));
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
